imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles MSB-first bytes into words and writes them to instruction memory
// while holding the CPU in reset. Define IMEM_LOADER_CHECKSUM_EN to add the cksum output.
module imem_loader #(
    parameter int size    = 32,
    parameter int MemSize = 128
) (
    input  logic            clka,
    input  logic            rsta,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            wea,
    output logic [size-1:0] addra,
    output logic [size-1:0] dina,
    output logic            cpu_hold,
    output logic            done,
    output logic            overflow,
    output logic [7:0]      word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]     cksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    localparam logic [size-1:0] Sentinel = {size{1'b1}};
    localparam logic [size-1:0] LastAddr = size'(MemSize - 1);

    state_t     state;
    logic [1:0] byte_idx;

    // Single FSM; every output is a register updated alongside the state transition.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            byte_idx   <= '0;
        end else begin
            wea <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        in_ready   <= 1'b1;
                        addra      <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        byte_idx   <= '0;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        dina     <= {dina[size-9:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            wea      <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    word_count <= word_count + 8'd1;
                    // The sentinel is itself written, and takes precedence over memory-full.
                    if (dina == Sentinel) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        overflow <= 1'b0;
                    end else if (addra == LastAddr) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        overflow <= 1'b1;
                    end else begin
                        addra    <= addra + 1'b1;
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of every word written this session, sentinel included.
    always_ff @(posedge clka) begin
        if (rsta) begin
            cksum <= '0;
        end else if ((state == IDLE || state == DONE) && start) begin
            cksum <= '0;
        end else if (wea) begin
            cksum <= cksum ^ 32'(dina);
        end
    end
`endif

endmodule
